gradient_nms: RTL and testbench

GRADIENT_NMS -- requirements
Module: gradient_nms

---
 rtl/ced_pkg.sv | 15 +
 rtl/grad_abs_diff.sv | 20 ++
 rtl/gradient_nms.sv | 151 +++++++++++++++
 tb/tb_gradient_nms.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ced_pkg.sv
// Shared definitions for the edge-detection chain: row geometry, sample width
// and the gradient/NMS row-sequencing states.
package ced_pkg;

  localparam int ROW_LEN = 150;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    FLUSH1 = 2'd2,
    FLUSH2 = 2'd3
  } state_t;

endpackage

// File: rtl/grad_abs_diff.sv
// Central-difference gradient: |a - b| and the direction of the difference.
module grad_abs_diff #(
  parameter int DATA_W = ced_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] mag_o,
  output logic              sign_o
);

  logic signed [DATA_W:0] diff;
  logic        [DATA_W:0] neg;

  // One extra bit holds the full signed range, so |diff| always fits DATA_W.
  assign diff   = $signed({1'b0, a_i}) - $signed({1'b0, b_i});
  assign neg    = -diff;
  assign mag_o  = diff[DATA_W] ? neg[DATA_W-1:0] : diff[DATA_W-1:0];
  assign sign_o = (a_i > b_i);

endmodule

// File: rtl/gradient_nms.sv
// Horizontal gradient magnitude with 1-D non-maximum suppression over one row,
// emitting one result per column with a two-cycle flush at the end of each row.
module gradient_nms #(
  parameter int ROW_LEN = ced_pkg::ROW_LEN,
  parameter int DATA_W  = ced_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic [DATA_W-1:0] In_Smoothed,
  input  logic [DATA_W-1:0] Threshold,
  output logic              InReady,
  output logic              OutValid,
  output logic [DATA_W-1:0] GradMag,
  output logic              GradSign,
  output logic              EdgeFlag,
  output logic              RowDone
);

  import ced_pkg::*;

  localparam int COL_W = $clog2(ROW_LEN);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_LEN - 1);

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [DATA_W-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [DATA_W-1:0] m_prev_q, m_prev_d, m_cur_q, m_cur_d;
  logic              s_cur_q, s_cur_d;
  logic              valid_q, valid_d, sign_q, sign_d, edge_q, edge_d, done_q, done_d;
  logic [DATA_W-1:0] mag_q, mag_d;

  logic              accept, emit, edge_now;
  logic [DATA_W-1:0] diff_mag, nxt_mag;
  logic              diff_sign;

  grad_abs_diff #(.DATA_W(DATA_W)) u_diff (
    .a_i    (In_Smoothed),
    .b_i    (x2_q),
    .mag_o  (diff_mag),
    .sign_o (diff_sign)
  );

  assign InReady = (state_q == FILL) || (state_q == RUN);
  assign accept  = enb && InReady;
  assign emit    = ((state_q == RUN) && accept) || (state_q == FLUSH1) || (state_q == FLUSH2);

  // Right-hand neighbour m[k+1]: arrives with the current sample, zero past the row end.
  assign nxt_mag  = (state_q == RUN) ? diff_mag : '0;
  assign edge_now = (m_cur_q >= Threshold) && (m_cur_q > m_prev_q) && (m_cur_q >= nxt_mag);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    col_d    = col_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    m_prev_d = m_prev_q;
    m_cur_d  = m_cur_q;
    s_cur_d  = s_cur_q;
    valid_d  = 1'b0;
    mag_d    = mag_q;
    sign_d   = sign_q;
    edge_d   = edge_q;
    done_d   = 1'b0;

    unique case (state_q)
      FILL: if (accept) begin
        x2_d  = x1_q;
        x1_d  = In_Smoothed;
        col_d = col_q + COL_W'(1);
        if (col_q == '0) begin
          // m[-1] and m[0] are both zero at the start of every row.
          m_prev_d = '0;
          m_cur_d  = '0;
          s_cur_d  = 1'b0;
        end
        if (col_q == COL_W'(1)) state_d = RUN;
      end
      RUN: if (accept) begin
        x2_d     = x1_q;
        x1_d     = In_Smoothed;
        m_prev_d = m_cur_q;
        m_cur_d  = diff_mag;
        s_cur_d  = diff_sign;
        if (col_q == LAST_COL) begin
          col_d   = '0;
          state_d = FLUSH1;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      FLUSH1: begin
        m_prev_d = m_cur_q;
        m_cur_d  = '0;
        s_cur_d  = 1'b0;
        state_d  = FLUSH2;
      end
      FLUSH2: begin
        done_d  = 1'b1;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase

    if (emit) begin
      valid_d = 1'b1;
      mag_d   = m_cur_q;
      sign_d  = s_cur_q;
      edge_d  = edge_now;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FILL;
      col_q    <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      m_prev_q <= '0;
      m_cur_q  <= '0;
      s_cur_q  <= 1'b0;
      valid_q  <= 1'b0;
      mag_q    <= '0;
      sign_q   <= 1'b0;
      edge_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      m_prev_q <= m_prev_d;
      m_cur_q  <= m_cur_d;
      s_cur_q  <= s_cur_d;
      valid_q  <= valid_d;
      mag_q    <= mag_d;
      sign_q   <= sign_d;
      edge_q   <= edge_d;
      done_q   <= done_d;
    end
  end

  assign OutValid = valid_q;
  assign GradMag  = mag_q;
  assign GradSign = sign_q;
  assign EdgeFlag = edge_q;
  assign RowDone  = done_q;

endmodule

// File: tb/tb_gradient_nms.sv
// Directed bench for gradient_nms: table of whole-row patterns with hand-computed
// probes, plus two-row back-to-back and mid-row reset sequences.
module tb_gradient_nms;

  localparam int N = ced_pkg::ROW_LEN;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enb = 1'b0;
  logic [7:0] In_Smoothed = '0;
  logic [7:0] Threshold = '0;
  logic       InReady, OutValid, GradSign, EdgeFlag, RowDone;
  logic [7:0] GradMag;

  gradient_nms dut (
    .clk         (clk),
    .reset       (reset),
    .enb         (enb),
    .In_Smoothed (In_Smoothed),
    .Threshold   (Threshold),
    .InReady     (InReady),
    .OutValid    (OutValid),
    .GradMag     (GradMag),
    .GradSign    (GradSign),
    .EdgeFlag    (EdgeFlag),
    .RowDone     (RowDone)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       done;
    logic       edg;
    logic       sign;
    logic [7:0] mag;
  } out_t;

  out_t cap[$];
  int   ready_low = 0;
  int   passed = 0;
  int   total = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (OutValid) cap.push_back({RowDone, EdgeFlag, GradSign, GradMag});
      if (!InReady) ready_low++;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Patterns: 0 ramp up, 1 step 10->200 at 75, 2 flat 5, 3 ramp down, 4 single 255 spike at 100.
  function automatic logic [7:0] gen(input int pat, input int c);
    case (pat)
      0:       return 8'(c);
      1:       return (c < 75) ? 8'd10 : 8'd200;
      2:       return 8'd5;
      3:       return 8'(N - 1 - c);
      default: return (c == 100) ? 8'd255 : 8'd0;
    endcase
  endfunction

  int exp_m[N];
  bit exp_s[N];
  bit exp_e[N];

  task automatic build_model(input int pat, input int thr);
    int a, b, prev, nxt;
    for (int k = 0; k < N; k++) begin
      if (k == 0 || k == N - 1) begin
        exp_m[k] = 0;
        exp_s[k] = 1'b0;
      end else begin
        a = int'(gen(pat, k + 1));
        b = int'(gen(pat, k - 1));
        exp_m[k] = (a > b) ? a - b : b - a;
        exp_s[k] = (a > b);
      end
    end
    for (int k = 0; k < N; k++) begin
      prev = (k == 0) ? 0 : exp_m[k-1];
      nxt  = (k == N - 1) ? 0 : exp_m[k+1];
      exp_e[k] = (exp_m[k] >= thr) && (exp_m[k] > prev) && (exp_m[k] >= nxt);
    end
  endtask

  task automatic drive_sample(input logic [7:0] x);
    int guard = 0;
    @(negedge clk);
    enb = 1'b1;
    In_Smoothed = x;
    while (!InReady && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (!InReady) begin
      total++;
      $display("FAIL ready_timeout: InReady got 0 expected 1 within 8 cycles");
    end
    @(posedge clk);
  endtask

  task automatic feed_row(input int pat, input int gap, input int ncols);
    for (int c = 0; c < ncols; c++) begin
      drive_sample(gen(pat, c));
      if (gap > 0) begin
        @(negedge clk);
        enb = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    enb = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_row(input string name, input int base);
    int got, exp;
    for (int k = 0; k < N; k++) begin
      got = (cap.size() > base + k) ? int'(cap[base+k]) : -1;
      exp = int'({(k == N - 1), exp_e[k], exp_s[k], 8'(exp_m[k])});
      check($sformatf("%s col%0d {done,edge,sign,mag}", name, k), got, exp);
    end
  endtask

  typedef struct {
    string name;
    int    pat;
    int    thr;
    int    gap;
    int    exp_edges;
    int    exp_first;
    int    probe_col;
    int    probe_mag;
    int    probe_sign;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  initial begin
    vecs[0] = '{"ramp_c0",      0, 1,   0, 1,  1, 0,   0,   0};
    vecs[1] = '{"ramp_c149",    0, 1,   0, 1,  1, 149, 0,   0};
    vecs[2] = '{"ramp_mid",     0, 1,   0, 1,  1, 75,  2,   1};
    vecs[3] = '{"step_t20",     1, 20,  0, 1, 74, 74,  190, 1};
    vecs[4] = '{"step_t200",    1, 200, 0, 0, -1, 75,  190, 1};
    vecs[5] = '{"step_gap",     1, 20,  1, 1, 74, 75,  190, 1};
    vecs[6] = '{"flat_t0",      2, 0,   0, 0, -1, 50,  0,   0};
    vecs[7] = '{"ramp_down",    3, 1,   0, 1,  1, 10,  2,   0};
    vecs[8] = '{"spike_t255",   4, 255, 0, 2, 99, 101, 255, 0};

    repeat (2) @(negedge clk);
    check("reset OutValid", int'(OutValid), 0);
    check("reset GradMag",  int'(GradMag),  0);
    check("reset flags",    int'({GradSign, EdgeFlag, RowDone}), 0);
    check("reset InReady",  int'(InReady),  1);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      int edges, first, dones;
      Threshold = 8'(vecs[v].thr);
      cap.delete();
      build_model(vecs[v].pat, vecs[v].thr);
      feed_row(vecs[v].pat, vecs[v].gap, N);
      idle(6);
      check({vecs[v].name, " pulses"}, cap.size(), N);
      check_row(vecs[v].name, 0);
      edges = 0;
      first = -1;
      dones = 0;
      for (int k = 0; k < cap.size(); k++) begin
        if (cap[k].edg) begin
          edges++;
          if (first < 0) first = k;
        end
        if (cap[k].done) dones++;
      end
      check({vecs[v].name, " edge count"}, edges, vecs[v].exp_edges);
      check({vecs[v].name, " first edge"}, first, vecs[v].exp_first);
      check({vecs[v].name, " rowdone count"}, dones, 1);
      if (cap.size() > vecs[v].probe_col) begin
        check({vecs[v].name, " probe mag"},  int'(cap[vecs[v].probe_col].mag),  vecs[v].probe_mag);
        check({vecs[v].name, " probe sign"}, int'(cap[vecs[v].probe_col].sign), vecs[v].probe_sign);
      end else begin
        check({vecs[v].name, " probe present"}, cap.size(), vecs[v].probe_col + 1);
      end
    end

    // Two rows back to back with enb held high: only the flush cycles stall.
    Threshold = 8'd1;
    cap.delete();
    ready_low = 0;
    build_model(0, 1);
    feed_row(0, 0, N);
    feed_row(0, 0, N);
    idle(6);
    check("2row pulses", cap.size(), 2 * N);
    check("2row stall cycles", ready_low, 4);
    check("2row rowdone at 149", (cap.size() > N - 1) ? int'(cap[N-1].done) : -1, 1);
    check("2row rowdone at 299", (cap.size() > 2 * N - 1) ? int'(cap[2*N-1].done) : -1, 1);
    check_row("2row r0", 0);
    check_row("2row r1", N);

    // Reset after column 60 of a step row, then a clean step row.
    Threshold = 8'd20;
    cap.delete();
    feed_row(1, 0, 61);
    @(negedge clk);
    enb = 1'b0;
    reset = 1'b1;
    #1;
    check("midreset OutValid", int'(OutValid), 0);
    check("midreset GradMag",  int'(GradMag),  0);
    check("midreset flags",    int'({GradSign, EdgeFlag, RowDone}), 0);
    check("midreset InReady",  int'(InReady),  1);
    @(negedge clk);
    reset = 1'b0;
    cap.delete();
    build_model(1, 20);
    feed_row(1, 0, N);
    idle(6);
    check("postreset pulses", cap.size(), N);
    check_row("postreset", 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
